// File: rtl/sha256_block_sequencer.sv
// Feeds padded 512-bit blocks of a word-aligned message to the SHA-256 compression core,
// chains each block's result into the next, then writes the 8-word digest to memory.
module sha256_block_sequencer #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       message_addr,
  input  logic [15:0]       output_addr,
  output logic              done,
  output logic [15:0]       mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  output logic              core_start,
  output logic [15:0][31:0] core_message,
  output logic [7:0][31:0]  core_hin,
  input  logic [7:0][31:0]  core_hout,
  input  logic              core_done
);
  localparam int          NUM_BLOCKS = (NUM_OF_WORDS + 3 + 15) / 16;
  localparam logic [31:0] NW         = 32'(NUM_OF_WORDS);
  localparam logic [31:0] MSG_BITS   = 32'(NUM_OF_WORDS * 32);
  localparam logic [15:0] LAST_BLK   = 16'(NUM_BLOCKS - 1);
  localparam logic [7:0][31:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                     32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  typedef enum logic [2:0] {IDLE, READ, ISSUE, WAIT, WRITE, DONE} state_t;
  state_t state_q, state_d;

  logic [4:0]        cnt_q;
  logic [15:0]       blk_q, maddr_q, oaddr_q;
  logic              rd_pend_q;
  logic [3:0]        rd_idx_q;
  logic [15:0][31:0] msg_q;
  logic [7:0][31:0]  hin_q;

  logic [31:0] g, pad_word;
  logic        rd_now, last_blk;

  assign g        = {12'd0, blk_q, 4'd0} + {27'd0, cnt_q};
  assign last_blk = (blk_q == LAST_BLK);
  // cnt_q==16 is a drain cycle that lets the final in-flight read land
  assign rd_now   = (state_q == READ) && !cnt_q[4] && (g < NW);

  always_comb begin
    pad_word = '0;
    if (last_blk && cnt_q == 5'd15) pad_word = MSG_BITS;
    else if (g == NW)               pad_word = 32'h8000_0000;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (cnt_q[4]) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (core_done) state_d = last_blk ? WRITE : READ;
      WRITE:   if (cnt_q == 5'd7) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done           = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    core_start     = 1'b0;
    case (state_q)
      READ:  if (rd_now) mem_addr = maddr_q + g[15:0];
      ISSUE: core_start = 1'b1;
      WRITE: begin
        mem_we         = 1'b1;
        mem_addr       = oaddr_q + {13'd0, cnt_q[2:0]};
        mem_write_data = hin_q[cnt_q[2:0]];
      end
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      blk_q     <= '0;
      maddr_q   <= '0;
      oaddr_q   <= '0;
      rd_pend_q <= 1'b0;
      rd_idx_q  <= '0;
      msg_q     <= '0;
      hin_q     <= '0;
    end else begin
      rd_pend_q <= rd_now;
      rd_idx_q  <= cnt_q[3:0];
      if (rd_pend_q) msg_q[rd_idx_q] <= mem_read_data;
      case (state_q)
        IDLE: if (start) begin
          maddr_q <= message_addr;
          oaddr_q <= output_addr;
          blk_q   <= '0;
          cnt_q   <= '0;
          hin_q   <= IV;
        end
        READ: begin
          if (cnt_q[4]) cnt_q <= '0;
          else begin
            cnt_q <= cnt_q + 5'd1;
            if (!rd_now) msg_q[cnt_q[3:0]] <= pad_word;
          end
        end
        WAIT: if (core_done) begin
          hin_q <= core_hout;
          cnt_q <= '0;
          if (!last_blk) blk_q <= blk_q + 16'd1;
        end
        WRITE: cnt_q <= cnt_q + 5'd1;
        default: ;
      endcase
    end
  end

  assign core_message = msg_q;
  assign core_hin     = hin_q;
endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Three sequencer instances (13, 20, 14 words) share a memory and core model selected by sel;
// a negedge monitor checks core transactions and digest writes against queued expectations.
module tb_sha256_block_sequencer;
  typedef struct {
    logic [15:0][31:0] msg;
    logic [7:0][31:0]  hin;
  } blk_t;
  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  localparam logic [7:0][31:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                     32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [2:0]        start_a;
  logic [15:0]       maddr, oaddr;
  logic [31:0]       rdata = '0;
  logic [7:0][31:0]  hout = '0;
  logic              cdone = 1'b0;
  logic              done_a [3], we_a [3], cs_a [3];
  logic [15:0]       addr_a [3];
  logic [31:0]       wd_a   [3];
  logic [15:0][31:0] msg_a  [3];
  logic [7:0][31:0]  hin_a  [3];

  sha256_block_sequencer #(.NUM_OF_WORDS(13)) u13 (.clk(clk), .reset_n(reset_n), .start(start_a[0]),
    .message_addr(maddr), .output_addr(oaddr), .done(done_a[0]), .mem_addr(addr_a[0]), .mem_we(we_a[0]),
    .mem_write_data(wd_a[0]), .mem_read_data(rdata), .core_start(cs_a[0]), .core_message(msg_a[0]),
    .core_hin(hin_a[0]), .core_hout(hout), .core_done(cdone));
  sha256_block_sequencer #(.NUM_OF_WORDS(20)) u20 (.clk(clk), .reset_n(reset_n), .start(start_a[1]),
    .message_addr(maddr), .output_addr(oaddr), .done(done_a[1]), .mem_addr(addr_a[1]), .mem_we(we_a[1]),
    .mem_write_data(wd_a[1]), .mem_read_data(rdata), .core_start(cs_a[1]), .core_message(msg_a[1]),
    .core_hin(hin_a[1]), .core_hout(hout), .core_done(cdone));
  sha256_block_sequencer #(.NUM_OF_WORDS(14)) u14 (.clk(clk), .reset_n(reset_n), .start(start_a[2]),
    .message_addr(maddr), .output_addr(oaddr), .done(done_a[2]), .mem_addr(addr_a[2]), .mem_we(we_a[2]),
    .mem_write_data(wd_a[2]), .mem_read_data(rdata), .core_start(cs_a[2]), .core_message(msg_a[2]),
    .core_hin(hin_a[2]), .core_hout(hout), .core_done(cdone));

  int sel = 0;
  int nw_tab [3] = '{13, 20, 14};
  logic              m_done, m_we, m_cs;
  logic [15:0]       m_addr, m_idx;
  logic [31:0]       m_wd;
  logic [15:0][31:0] m_msg;
  logic [7:0][31:0]  m_hin;
  always_comb begin
    m_done = done_a[sel]; m_we = we_a[sel]; m_cs = cs_a[sel];
    m_addr = addr_a[sel]; m_wd = wd_a[sel]; m_msg = msg_a[sel]; m_hin = hin_a[sel];
    m_idx  = m_addr - maddr;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [7:0][31:0] sha_comp(input logic [7:0][31:0] h, input logic [15:0][31:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    logic [7:0][31:0] r;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++)
      w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-7]
           + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
    a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    r[0] = h[0] + a; r[1] = h[1] + b; r[2] = h[2] + c; r[3] = h[3] + d;
    r[4] = h[4] + e; r[5] = h[5] + f; r[6] = h[6] + g; r[7] = h[7] + hh;
    return r;
  endfunction

  // memory: message word i holds i+1; anything else reads as a marker value
  always @(posedge clk)
    rdata <= (!m_we && int'(m_idx) < nw_tab[sel]) ? 32'(m_idx) + 32'd1 : 32'hDEADBEEF;

  // compression core model with programmable latency
  int delay = 3, busy_cnt = 0;
  bit busy = 1'b0, stable_ok = 1'b1;
  logic [15:0][31:0] s_msg;
  logic [7:0][31:0]  s_hin;
  always @(posedge clk) begin
    cdone <= 1'b0;
    if (busy) begin
      if (m_msg !== s_msg || m_hin !== s_hin) stable_ok <= 1'b0;
      if (busy_cnt <= 1) begin
        cdone <= 1'b1;
        hout  <= sha_comp(s_hin, s_msg);
        busy  <= 1'b0;
      end else busy_cnt <= busy_cnt - 1;
    end else if (m_cs) begin
      s_msg <= m_msg; s_hin <= m_hin; busy <= 1'b1; busy_cnt <= delay; stable_ok <= 1'b1;
    end
  end

  blk_t q_blk [$];
  wr_t  q_wr  [$];
  int   done_cnt = 0, cs_cnt = 0;

  always @(negedge clk) if (reset_n) begin
    if (m_cs) begin
      cs_cnt++;
      if (q_blk.size() == 0) chk("unexpected_core_start", 1, 0);
      else begin
        blk_t b;
        b = q_blk.pop_front();
        chk("core_message", m_msg, b.msg);
        chk("core_hin", m_hin, b.hin);
      end
    end
    if (m_we) begin
      if (q_wr.size() == 0) chk("unexpected_write", {m_addr, m_wd}, 0);
      else begin
        wr_t w;
        w = q_wr.pop_front();
        chk("wr_addr", m_addr, w.addr);
        chk("wr_data", m_wd, w.data);
      end
    end
    if (m_done) begin
      done_cnt++;
      chk("writes_before_done", q_wr.size(), 0);
    end
    if (cdone) chk("core_inputs_stable", stable_ok, 1);
  end

  task automatic push_blk(input logic [15:0][31:0] m, input logic [7:0][31:0] hi, output logic [7:0][31:0] ho);
    blk_t b;
    b.msg = m; b.hin = hi;
    q_blk.push_back(b);
    ho = sha_comp(hi, m);
  endtask

  task automatic push_digest(input logic [15:0] oa, input logic [7:0][31:0] h);
    wr_t w;
    for (int k = 0; k < 8; k++) begin
      w.addr = oa + 16'(k); w.data = h[k];
      q_wr.push_back(w);
    end
  endtask

  task automatic run(input int s, input int nblk, input bit poke);
    sel = s; done_cnt = 0; cs_cnt = 0;
    @(negedge clk); start_a[s] = 1'b1;
    @(negedge clk); start_a[s] = 1'b0;
    if (poke) begin
      for (int c = 0; c < 2000 && cs_cnt < 1; c++) @(negedge clk);
      repeat (10) @(negedge clk);
      start_a[s] = 1'b1;
      @(negedge clk); start_a[s] = 1'b0;
    end
    for (int c = 0; c < 5000 && done_cnt == 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("core_start_count", cs_cnt, nblk);
    chk("blk_queue_empty", q_blk.size(), 0);
    chk("wr_queue_empty", q_wr.size(), 0);
  endtask

  task automatic exp20(input logic [15:0] oa);
    logic [15:0][31:0] m;
    logic [7:0][31:0]  h0, h1;
    for (int j = 0; j < 16; j++) m[j] = 32'(j + 1);
    push_blk(m, IV, h0);
    m = '0;
    for (int j = 0; j < 4; j++) m[j] = 32'(j + 17);
    m[4] = 32'h8000_0000; m[15] = 32'h0000_0280;
    push_blk(m, h0, h1);
    push_digest(oa, h1);
  endtask

  task automatic exp13(input logic [15:0] oa);
    logic [15:0][31:0] m;
    logic [7:0][31:0]  h;
    m = '0;
    for (int j = 0; j < 13; j++) m[j] = 32'(j + 1);
    m[13] = 32'h8000_0000; m[15] = 32'h0000_01A0;
    push_blk(m, IV, h);
    push_digest(oa, h);
  endtask

  initial begin
    logic [15:0][31:0] m;
    logic [7:0][31:0]  h0, h1;
    reset_n = 1'b0; start_a = '0; maddr = 16'h0100; oaddr = 16'h0200;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("rst_outputs", {done_a[s], we_a[s], cs_a[s], addr_a[s], wd_a[s]}, 0);
      chk("rst_core_msg_hin", {msg_a[s], hin_a[s][7:0]}, 0);
    end
    reset_n = 1'b1;

    m = '0; m[0] = 32'h6162_6380; m[15] = 32'h18;
    h0 = sha_comp(IV, m);
    chk("golden_abc", {h0[0], h0[7]}, {32'hba7816bf, 32'hf20015ad});

    exp13(16'h0200);
    run(0, 1, 1'b0);

    exp20(16'h0200);
    run(1, 2, 1'b0);

    m = '0;
    for (int j = 0; j < 14; j++) m[j] = 32'(j + 1);
    m[14] = 32'h8000_0000;
    push_blk(m, IV, h0);
    m = '0; m[15] = 32'h0000_01C0;
    push_blk(m, h0, h1);
    push_digest(16'h0200, h1);
    run(2, 2, 1'b0);

    delay = 100;
    exp20(16'h0200);
    run(1, 2, 1'b1);
    delay = 3;

    oaddr = 16'h0300; sel = 1;
    exp20(16'h0300);
    @(negedge clk); start_a[1] = 1'b1;
    @(negedge clk); start_a[1] = 1'b0;
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 3000 && !hit; c++) begin
        @(negedge clk);
        hit = m_we && (m_addr == 16'h0303);
      end
      chk("reached_write_k3", hit, 1);
    end
    #2 reset_n = 1'b0;
    #1 chk("abort_outputs", {m_we, m_done, m_cs, m_addr, m_wd}, 0);
    q_wr.delete();
    q_blk.delete();
    @(negedge clk); reset_n = 1'b1;
    repeat (5) @(negedge clk);
    exp20(16'h0300);
    run(1, 2, 1'b0);

    oaddr = 16'hFFFE;
    exp13(16'hFFFE);
    run(0, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
